imm_ext_arbiter: RTL and testbench

Shares the single sign/zero immediate extender between two requesters in the processor datapath: the branch-offset path (requester 0) and the ALU immediate path (requester 1). It accepts one request per cycle under round-robin arbitration and extends the selected IN_W-bit field to OUT_W bits. The result is held in a registered single-entry response slot with a valid/ready handshake. The downstream consumer receives the result tagged with the requester ID.

---
 rtl/imm_ext_arbiter.sv | 76 +++++++
 tb/tb_imm_ext_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one sign/zero immediate extender between the
// branch-offset (0) and ALU-immediate (1) requesters, with a registered slot.
module imm_ext_arbiter #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic             req0_signed,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  input  logic             req1_signed,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready
);

  localparam int EXT_W = OUT_W - IN_W;

  if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_width
    $error("imm_ext_arbiter: IN_W must be >= 2 and < OUT_W");
  end

  logic             last_grant;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             take;
  logic             sel_signed;
  logic [IN_W-1:0]  sel_data;
  logic [OUT_W-1:0] ext_data;

  assign slot_free = !rsp_valid || rsp_ready;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = !reset && slot_free && grant0;
  assign req1_ready = !reset && slot_free && grant1;

  assign take = req0_ready || req1_ready;

  always_comb begin
    sel_data   = req0_data;
    sel_signed = req0_signed;
    if (req1_ready) begin
      sel_data   = req1_data;
      sel_signed = req1_signed;
    end
  end

  assign ext_data = {{EXT_W{sel_signed & sel_data[IN_W-1]}}, sel_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (take) begin
      rsp_valid  <= 1'b1;
      rsp_data   <= ext_data;
      rsp_id     <= req1_ready;
      last_grant <= req1_ready;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed-vector bench: driver pushes expected responses into a
// scoreboard queue, a separate monitor pops and compares slot contents.
module tb_imm_ext_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic [3:0]  req0_data;
  logic        req0_signed;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_data;
  logic        req1_signed;
  logic        req1_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready;

  imm_ext_arbiter #(.IN_W(4), .OUT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_signed (req0_signed),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_signed (req1_signed),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_ready   (rsp_ready)
  );

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic [3:0]  d0;
    logic        s0;
    logic        v1;
    logic [3:0]  d1;
    logic        s1;
    logic        rr;
    logic        er0;
    logic        er1;
    logic [15:0] ed;
    logic        he;
    logic [15:0] hd;
    logic        hi;
  } vec_t;

  vec_t        vt[$];
  logic [16:0] sb[$];
  int          n_chk;
  int          n_fail;
  bit          started;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic v0, input logic [3:0] d0, input logic s0,
    input logic v1, input logic [3:0] d1, input logic s1, input logic rr,
    input logic er0, input logic er1, input logic [15:0] ed,
    input logic he, input logic [15:0] hd, input logic hi);
    vec_t v;
    v = {rst, v0, d0, s0, v1, d1, s1, rr, er0, er1, ed, he, hd, hi};
    return v;
  endfunction

  // Monitor: slot valid must match outstanding expectations.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (started) begin
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, sb.size() > 0});
        if (rsp_valid && sb.size() > 0) begin
          chk("rsp_id_data", {15'd0, rsp_id, rsp_data}, {15'd0, sb[0]});
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    started = 0;
    reset = 1; rsp_ready = 0;
    req0_valid = 0; req0_data = 0; req0_signed = 0;
    req1_valid = 0; req1_data = 0; req1_signed = 0;

    // reset, with requests presented that must not be taken
    vt.push_back(mk(1,1,4'hF,1, 0,4'h0,0, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(1,1,4'hF,1, 1,4'hF,1, 0, 0,0,16'h0000, 1,16'h0000,0));
    // sign / zero extension, requester 0 alone
    vt.push_back(mk(0,1,4'hF,1, 0,4'h0,0, 1, 1,0,16'hFFFF, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'hF,0, 0,4'h0,0, 1, 1,0,16'h000F, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h7,1, 0,4'h0,0, 1, 1,0,16'h0007, 0,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 1,16'h0007,0));
    // re-reset, then ties alternate 0,1,0,1 at full rate
    vt.push_back(mk(1,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'hA,1, 1,4'h5,1, 1, 1,0,16'hFFFA, 1,16'h0000,0));
    vt.push_back(mk(0,1,4'h9,0, 1,4'h5,1, 1, 0,1,16'h0005, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h9,0, 1,4'hC,0, 1, 1,0,16'h0009, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h3,1, 1,4'hC,0, 1, 0,1,16'h000C, 0,16'h0000,0));
    // backpressure: slot held three cycles, then drain + refill
    vt.push_back(mk(0,1,4'h3,1, 1,4'h8,1, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h3,1, 1,4'h8,1, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h3,1, 1,4'h8,1, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h3,1, 1,4'h8,1, 1, 1,0,16'h0003, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h6,1, 1,4'h8,1, 1, 0,1,16'hFFF8, 0,16'h0000,0));
    // fairness: req1 always valid, req0 back-to-back
    vt.push_back(mk(0,1,4'h6,1, 1,4'h2,0, 1, 1,0,16'h0006, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'hB,1, 1,4'h2,0, 1, 0,1,16'h0002, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'hB,1, 1,4'hE,1, 1, 1,0,16'hFFFB, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h1,0, 1,4'hE,1, 1, 0,1,16'hFFFE, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h1,0, 1,4'h7,0, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h1,0, 1,4'h7,0, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h1,0, 1,4'h7,0, 1, 1,0,16'h0001, 0,16'h0000,0));
    // reset with a pending response, then tie goes to requester 0
    vt.push_back(mk(0,1,4'h4,1, 1,4'h7,0, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(1,1,4'h4,1, 1,4'h7,0, 0, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,1,4'h4,1, 1,4'h7,0, 0, 1,0,16'h0004, 1,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 1,4'h7,0, 1, 0,1,16'h0007, 0,16'h0000,0));
    // idle: slot drains, data and id hold
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 1,16'h0007,1));
    vt.push_back(mk(0,0,4'h0,0, 1,4'hF,1, 1, 0,1,16'hFFFF, 0,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 0,16'h0000,0));
    vt.push_back(mk(0,0,4'h0,0, 0,4'h0,0, 1, 0,0,16'h0000, 1,16'hFFFF,1));

    for (int i = 0; i < vt.size(); i++) begin
      vec_t v;
      v = vt[i];
      @(posedge clock);
      #1;
      if (i == 1) started = 1;
      reset       = v.rst;
      req0_valid  = v.v0;
      req0_data   = v.d0;
      req0_signed = v.s0;
      req1_valid  = v.v1;
      req1_data   = v.d1;
      req1_signed = v.s1;
      rsp_ready   = v.rr;
      @(negedge clock);
      #2;
      chk($sformatf("req0_ready[%0d]", i), {31'd0, req0_ready}, {31'd0, v.er0});
      chk($sformatf("req1_ready[%0d]", i), {31'd0, req1_ready}, {31'd0, v.er1});
      if (v.he)
        chk($sformatf("hold[%0d]", i), {15'd0, rsp_id, rsp_data},
            {15'd0, v.hi, v.hd});
      if (v.er0 && v.v0) sb.push_back({1'b0, v.ed});
      if (v.er1 && v.v1) sb.push_back({1'b1, v.ed});
      if (v.rst) sb.delete();
    end

    @(posedge clock);
    #1;
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clock);
    #2;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
